// File: rtl/whack_round_ctrl.sv
// Whack-a-mole round controller: picks a pseudo-random mole, times the
// visible window, scores hits, charges lives for misses and shrinks the window
// as the player keeps hitting.
module whack_round_ctrl #(
  parameter int          GAP_TICKS    = 200,
  parameter int          WINDOW_TICKS = 500,
  parameter int          MIN_WINDOW   = 100,
  parameter int          SPEEDUP      = 25,
  parameter int          LIVES        = 3,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [2:0] lives_left,
  output logic       busy,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam logic [15:0] GAP_C   = 16'(GAP_TICKS);
  localparam logic [15:0] WIN_C   = 16'(WINDOW_TICKS);
  localparam logic [15:0] MIN_C   = 16'(MIN_WINDOW);
  localparam logic [15:0] SPD_C   = 16'(SPEEDUP);
  localparam logic [2:0]  LIVES_C = 3'(LIVES);

  typedef enum logic [1:0] {IDLE, ARM, SHOW, OVER} state_t;

  state_t      state;
  logic [7:0]  lfsr;
  logic [3:0]  btn_q;
  logic [15:0] cnt;
  logic [15:0] window;
  logic [1:0]  idx;       // lit index while in SHOW, last shown index otherwise

  logic [3:0]  edges;
  logic [3:0]  lit;
  logic        wrong;
  logic        good;
  logic [1:0]  pick;
  logic [15:0] win_next;

  // Button edges, hit/miss classification, next index and next window
  always_comb begin
    edges    = btn & ~btn_q;
    lit      = 4'b0001 << idx;
    wrong    = |(edges & ~lit);
    good     = |(edges & lit);
    pick     = (lfsr[1:0] == idx) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
    win_next = MIN_C;
    if ({1'b0, window} >= ({1'b0, MIN_C} + {1'b0, SPD_C}))
      win_next = window - SPD_C;
  end

  // Free-running Galois LFSR, x^8+x^6+x^5+x^4+1 (right-shift form)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end

  // Button history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 4'd0;
    else     btn_q <= btn;
  end

  // Round FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mole       <= 4'd0;
      score      <= 8'd0;
      lives_left <= LIVES_C;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      window     <= WIN_C;
      cnt        <= 16'd0;
      idx        <= 2'd0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score      <= 8'd0;
            lives_left <= LIVES_C;
            window     <= WIN_C;
            cnt        <= GAP_C;
            busy       <= 1'b1;
            game_over  <= 1'b0;
            mole       <= 4'd0;
            state      <= ARM;
          end
        end
        ARM: begin
          if (cnt == 16'd0) begin
            idx   <= pick;
            mole  <= 4'b0001 << pick;
            cnt   <= window;
            state <= SHOW;
          end else if (tick) begin
            cnt <= cnt - 16'd1;
          end
        end
        SHOW: begin
          // A wrong edge beats a simultaneous correct one; a correct edge
          // beats the window running out in the same cycle.
          if (wrong || (!good && cnt == 16'd0)) begin
            miss_pulse <= 1'b1;
            lives_left <= lives_left - 3'd1;
            mole       <= 4'd0;
            cnt        <= GAP_C;
            if (lives_left == 3'd1) begin
              busy      <= 1'b0;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              state <= ARM;
            end
          end else if (good) begin
            hit_pulse <= 1'b1;
            if (score != 8'hFF) score <= score + 8'd1;
            window <= win_next;
            mole   <= 4'd0;
            cnt    <= GAP_C;
            state  <= ARM;
          end else if (tick) begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Bench for whack_round_ctrl: a rule-level game model predicts every mole,
// hit and miss (with its cycle); a monitor pops and compares as the DUT emits.
module tb_whack_round_ctrl;

  localparam int GAP = 2, WIN = 4, MINW = 2, SPD = 1, LIV = 3;

  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, start = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [3:0] mole;
  logic [7:0] score;
  logic [2:0] lives_left;
  logic       busy, game_over, hit_pulse, miss_pulse;

  whack_round_ctrl #(
    .GAP_TICKS(GAP), .WINDOW_TICKS(WIN), .MIN_WINDOW(MINW), .SPEEDUP(SPD),
    .LIVES(LIV), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .btn(btn),
    .mole(mole), .score(score), .lives_left(lives_left), .busy(busy),
    .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, tdiv = 0;

  // tick every 4 cycles, changed just after the edge
  always @(posedge clk) begin
    #1;
    tick = (tdiv == 3);
    tdiv = (tdiv + 1) % 4;
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int kind; int at; int score; int lives; int mole; } ev_t; // kind 0 show,1 hit,2 miss
  ev_t q[$];

  int m_phase;   // 0 idle, 1 waiting gap, 2 mole up, 3 game over
  int m_left, m_win, m_score, m_lives, m_last, m_lfsr, m_btn_prev;
  int e, w, pidx;

  function automatic int lfsr_step(int v);
    return (v >> 1) ^ (((v & 1) != 0) ? 'hB8 : 0);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase = 0; m_left = 0; m_win = WIN; m_score = 0; m_lives = LIV;
      m_last = 0; m_lfsr = 'hA5; m_btn_prev = 0;
    end else begin
      e = int'(btn) & ~m_btn_prev & 'hF;
      m_btn_prev = int'(btn);
      case (m_phase)
        0, 3: if (start) begin
          m_score = 0; m_lives = LIV; m_win = WIN; m_left = GAP; m_phase = 1;
        end
        1: begin
          if (m_left == 0) begin
            pidx = m_lfsr & 3;
            if (pidx == m_last) pidx = (pidx + 1) % 4;
            m_last = pidx; m_left = m_win; m_phase = 2;
            q.push_back(ev_t'{0, cyc, m_score, m_lives, 1 << pidx});
          end else if (tick) m_left--;
        end
        2: begin
          w = e & ~(1 << m_last) & 'hF;
          if (w != 0 || (((e >> m_last) & 1) == 0 && m_left == 0)) begin
            m_lives--; m_left = GAP;
            m_phase = (m_lives == 0) ? 3 : 1;
            q.push_back(ev_t'{2, cyc, m_score, m_lives, 0});
          end else if (((e >> m_last) & 1) != 0) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_win = (m_win - SPD < MINW) ? MINW : m_win - SPD;
            m_left = GAP; m_phase = 1;
            q.push_back(ev_t'{1, cyc, m_score, m_lives, 0});
          end else if (tick) m_left--;
        end
        default: m_phase = 0;
      endcase
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // ---------------- monitor ----------------
  int prev_mole = 0, last_shown = -1, shows = 0;

  task automatic take(int kind);
    ev_t ev;
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      ev = q.pop_front();
      check("event_kind", kind, ev.kind);
      check("event_cycle", cyc, ev.at);
      if (kind == 0) check("show_mole", int'(mole), ev.mole);
      else begin
        check("event_score", int'(score), ev.score);
        check("event_lives", int'(lives_left), ev.lives);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_mole = 0; last_shown = -1;
    end else begin
      while (q.size() > 0 && q[0].at < cyc) begin
        checks++; failures++;
        $display("FAIL missing_event: got nothing expected kind %0d at cycle %0d", q[0].kind, q[0].at);
        void'(q.pop_front());
      end
      if (hit_pulse)  take(1);
      if (miss_pulse) take(2);
      if (mole != 0 && prev_mole == 0) begin
        take(0);
        check("mole_onehot", int'($onehot(mole)), 1);
        check("mole_no_repeat", int'(int'(mole) != last_shown), 1);
        last_shown = int'(mole);
        shows++;
      end
      prev_mole = int'(mole);
      check("score", int'(score), m_score);
      check("lives_left", int'(lives_left), m_lives);
      check("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
      check("game_over", int'(game_over), int'(m_phase == 3));
      check("mole", int'(mole), (m_phase == 2) ? (1 << m_last) : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_wait(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    start = 1'b1; cyc_wait(1); start = 1'b0;
  endtask

  task automatic wait_mole();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (mole != 0) begin ok = 1; break; end
      cyc_wait(1);
    end
    check("wait_mole_timeout", int'(ok), 1);
  endtask

  task automatic hit_once();
    wait_mole();
    cyc_wait($urandom_range(0, 1));
    btn = mole; cyc_wait(1);
    btn = 4'd0; cyc_wait(1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_mole"}, int'(mole), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_lives"}, int'(lives_left), LIV);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_hit"}, int'(hit_pulse), 0);
    check({tag, "_miss"}, int'(miss_pulse), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, base, n;
    bit ok;
    rst = 1'b1;
    cyc_wait(3);
    check_reset_outputs("reset");
    @(negedge clk); #1 rst = 1'b0;
    cyc_wait(2);

    // untouched game: three timed-out moles, then game over
    do_start();
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (game_over) begin ok = 1; break; end
      cyc_wait(1);
    end
    check("over_after_misses", int'(ok), 1);
    check("over_lives", int'(lives_left), 0);
    check("over_mole", int'(mole), 0);

    // five hits, then reset while a mole is up
    do_start();
    repeat (5) hit_once();
    check("score_five", int'(score), 5);
    wait_mole();
    @(negedge clk); #1 rst = 1'b1;
    #2 check_reset_outputs("midgame_reset");
    cyc_wait(2);
    @(negedge clk); #1 rst = 1'b0;
    cyc_wait(2);

    // restart, hit until the window reaches its floor
    do_start();
    repeat (3) hit_once();
    check("score_three", int'(score), 3);

    // correct and wrong button in the same cycle -> miss
    wait_mole();
    btn = mole | {mole[2:0], mole[3]};
    cyc_wait(1);
    btn = 4'd0;
    cyc_wait(1);
    check("both_score_kept", int'(score), 3);
    check("both_lives_dec", int'(lives_left), LIV - 1);

    // all buttons held into SHOW: no hit until the lit one is re-pressed
    btn = 4'hF;
    wait_mole();
    cyc_wait(1);
    check("held_no_hit", int'(score), 3);
    btn = 4'hF & ~mole; cyc_wait(1);
    btn = 4'hF; cyc_wait(1);
    check("repress_hit", int'(score), 4);
    btn = 4'd0;
    cyc_wait(2);

    // random play for 100 consecutive moles, restarting as games end
    base = shows; n = 0;
    while (shows - base < 100 && n < 30000) begin
      if (!busy) do_start();
      else begin
        r = $urandom_range(0, 7);
        if (r < 2) btn = mole;
        else if (r == 2) btn = 4'($urandom_range(0, 15));
        else btn = 4'd0;
        cyc_wait(1);
      end
      n++;
    end
    btn = 4'd0;
    check("hundred_moles", int'(shows - base >= 100), 1);
    cyc_wait(5);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
